mac_acc_drain: RTL and testbench

Output-side drain for the MAC accumulator block. Captures one four-lane snapshot of accumulator results (`out0`..`out3`) together with its MAC mode, regroups the lanes into logical results (single: four, dual: two, quad: one), and streams them as `ACC_WIDTH`-bit beats over a valid/ready interface toward the fabric or host readback path. Sits directly downstream of the accumulator block and is the reader for the values that block writes.

---
 rtl/mac_acc_drain.sv | 111 +++++++++++
 tb/tb_mac_acc_drain.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_drain.sv
// Output drain for the MAC accumulator: captures a four-lane snapshot and
// streams it as framed beats over valid/ready, with back-to-back capture.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif

module mac_acc_drain #(
  parameter int ACC_WIDTH = `MAC_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [ACC_WIDTH-1:0] lane0,
  input  logic [ACC_WIDTH-1:0] lane1,
  input  logic [ACC_WIDTH-1:0] lane2,
  input  logic [ACC_WIDTH-1:0] lane3,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ACC_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [1:0]           m_res,
  output logic                 m_end,
  output logic                 overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_nxt;
  logic [1:0]           idx;
  logic [1:0]           mode_q;
  logic [ACC_WIDTH-1:0] lane_buf [4];
  logic                 capture;
  logic                 transfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The final-beat cycle of SEND accepts a new snapshot so there is no idle bubble.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    m_valid   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEND;
      end
      SEND: begin
        m_valid  = 1'b1;
        in_ready = (idx == 2'd3) && m_ready;
        if (m_ready && (idx == 2'd3) && !in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign capture  = in_valid && in_ready;
  assign transfer = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= 2'd0;
      mode_q   <= 2'b00;
      overflow <= 1'b0;
      for (int i = 0; i < 4; i++) lane_buf[i] <= '0;
    end else begin
      if (capture) begin
        lane_buf[0] <= lane0;
        lane_buf[1] <= lane1;
        lane_buf[2] <= lane2;
        lane_buf[3] <= lane3;
        mode_q      <= mode;
        idx         <= 2'd0;
      end else if (transfer) begin
        idx <= idx + 2'd1;
      end
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // Framing is decoded from the captured mode; mode 2'b11 falls into the single case.
  always_comb begin
    m_data = '0;
    m_last = 1'b0;
    m_res  = 2'd0;
    m_end  = 1'b0;
    if (state == SEND) begin
      m_data = lane_buf[idx];
      m_end  = (idx == 2'd3);
      case (mode_q)
        2'b01: begin
          m_last = idx[0];
          m_res  = {1'b0, idx[1]};
        end
        2'b10: begin
          m_last = (idx == 2'd3);
          m_res  = 2'd0;
        end
        default: begin
          m_last = 1'b1;
          m_res  = idx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc_drain.sv
// Bench for mac_acc_drain: directed scenarios then random traffic, checked
// against a queue of expected beats built from the framing rules.
module tb_mac_acc_drain;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] lane0, lane1, lane2, lane3;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic [1:0]   m_res;
  logic         m_end;
  logic         overflow;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [1:0]   res;
    logic         fin;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_ovf;
  int    assert_count = 0;
  int    fail_count   = 0;

  mac_acc_drain #(.ACC_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .lane0    (lane0),
    .lane1    (lane1),
    .lane2    (lane2),
    .lane3    (lane3),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_res    (m_res),
    .m_end    (m_end),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic beat_t make_beat(logic [W-1:0] d, int i, logic [1:0] md);
    beat_t b;
    b.data = d;
    b.fin  = (i == 3);
    if (md == 2'b01) begin
      b.last = (i % 2 == 1);
      b.res  = 2'(i / 2);
    end else if (md == 2'b10) begin
      b.last = (i == 3);
      b.res  = 2'd0;
    end else begin
      b.last = 1'b1;
      b.res  = 2'(i);
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (exp_q.size() == 0) || (exp_q.size() == 1 && m_ready);
  endfunction

  task automatic checkOutput();
    chk("in_ready", 32'(in_ready), 32'(model_ready()));
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) begin
      chk("m_data", 32'(m_data), 32'(exp_q[0].data));
      chk("m_last", 32'(m_last), 32'(exp_q[0].last));
      chk("m_res", 32'(m_res), 32'(exp_q[0].res));
      chk("m_end", 32'(m_end), 32'(exp_q[0].fin));
    end
  endtask

  task automatic model_step();
    logic         rdy;
    logic [W-1:0] l [4];
    rdy = model_ready();
    l[0] = lane0; l[1] = lane1; l[2] = lane2; l[3] = lane3;
    if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
    if (in_valid && rdy) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(make_beat(l[i], i, mode));
    end else if (in_valid) begin
      exp_ovf = 1'b1;
    end
  endtask

  // One cycle: drive, check mid-cycle, advance the model on the edge.
  task automatic applyStimulus(input logic iv, input logic [1:0] md,
                               input logic [W-1:0] l0, input logic [W-1:0] l1,
                               input logic [W-1:0] l2, input logic [W-1:0] l3,
                               input logic mr);
    in_valid = iv; mode = md; m_ready = mr;
    lane0 = l0; lane1 = l1; lane2 = l2; lane3 = l3;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic mr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom_range(0, 3), '0, '0, '0, '0, mr);
  endtask

  task automatic check_reset_outputs();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_res", 32'(m_res), 32'd0);
    chk("rst_m_end", 32'(m_end), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; m_ready = 1'b0;
    lane0 = '0; lane1 = '0; lane2 = '0; lane3 = '0;
    exp_ovf = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single mode");
    applyStimulus(1'b1, 2'b00, 16'h11, 16'h22, 16'h33, 16'h44, 1'b1);
    idle_cycles(5, 1'b1);

    $display("[TB] dual and quad mode");
    applyStimulus(1'b1, 2'b01, 16'hA0, 16'hA1, 16'hA2, 16'hA3, 1'b1);
    idle_cycles(5, 1'b1);
    applyStimulus(1'b1, 2'b10, 16'hA0, 16'hA1, 16'hA2, 16'hA3, 1'b1);
    idle_cycles(5, 1'b1);
    applyStimulus(1'b1, 2'b11, 16'hB0, 16'hB1, 16'hB2, 16'hB3, 1'b1);
    idle_cycles(5, 1'b1);

    $display("[TB] backpressure at beat 1");
    applyStimulus(1'b1, 2'b01, 16'hC0, 16'hC1, 16'hC2, 16'hC3, 1'b1);
    idle_cycles(1, 1'b1);
    idle_cycles(3, 1'b0);
    idle_cycles(5, 1'b1);

    $display("[TB] back-to-back snapshots");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 2'b00, (i < 4) ? 16'h1 : 16'h5, (i < 4) ? 16'h2 : 16'h6,
                    (i < 4) ? 16'h3 : 16'h7, (i < 4) ? 16'h4 : 16'h8, 1'b1);
    idle_cycles(5, 1'b1);

    $display("[TB] overflow and mid-stream reset");
    rst = 1'b1; #1; exp_q.delete(); exp_ovf = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 2'b00, 16'hD0, 16'hD1, 16'hD2, 16'hD3, 1'b1);
    idle_cycles(1, 1'b1);
    applyStimulus(1'b1, 2'b10, 16'hEE, 16'hEE, 16'hEE, 16'hEE, 1'b0);
    idle_cycles(2, 1'b0);
    idle_cycles(1, 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    #2; rst = 1'b1; #1;
    exp_q.delete(); exp_ovf = 1'b0;
    check_reset_outputs();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 2'b01, 16'hF0, 16'hF1, 16'hF2, 16'hF3, 1'b1);
    idle_cycles(5, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        rst = 1'b1; #1; exp_q.delete(); exp_ovf = 1'b0;
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
      end
      applyStimulus($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                    W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    $urandom_range(0, 3) != 0);
    end
    idle_cycles(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
